// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH stages with valid/ready handshake and bubble collapsing.
// Outputs come straight from the last stage's flops; in_ready is combinational from out_ready.
module pipe_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] adv_c;
  logic             in_xfer_c;
  logic [CW-1:0]    count_c;

  // Advance ripples from the output side: a stage may move if the next one is empty or moving.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    adv_c            = '0;
    adv_c[DEPTH-1]   = valid_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv_c[i] = valid_q[i] & (~valid_q[i+1] | adv_c[i+1]);
    end
  end

  assign in_ready  = (~valid_q[0] | adv_c[0]) & ~flush;
  assign in_xfer_c = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;

    if (in_xfer_c) begin
      valid_d[0] = 1'b1;
      data_d[0]  = in_data;
    end else if (adv_c[0]) begin
      valid_d[0] = 1'b0;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (adv_c[i-1]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = data_q[i-1];
      end else if (adv_c[i]) begin
        valid_d[i] = 1'b0;
      end
    end

    // Flush discards every word, including one being handed to the consumer this cycle.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      // NOTE: the data array is reset too, because out_data must read zero while rst is held.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all stages update from old values.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_c = count_c + CW'(valid_q[i]);
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign count     = count_c;

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a word-position reference model.
module tb_pipe_reg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk       = 1'b0;
  logic             rst       = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Reference model: the ordered list of words in flight, each tagged with its stage number.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               pos;
  } word_t;
  typedef word_t wq_t[$];

  wq_t mq;
  wq_t m_nq;
  wq_t c_nq;

  // One clock of movement: the oldest word leaves from the last stage when the consumer is
  // ready; every other word steps forward if the slot ahead is free after the word in front moved.
  function automatic void advance(input wq_t q, input bit ordy, output wq_t nq);
    int ahead;
    nq    = {};
    ahead = DEPTH;
    foreach (q[k]) begin
      word_t w;
      w = q[k];
      if (w.pos == DEPTH - 1) begin
        if (ordy) begin
          ahead = DEPTH;
          continue;
        end
      end else if (w.pos + 1 < ahead) begin
        w.pos = w.pos + 1;
      end
      ahead = w.pos;
      nq.push_back(w);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
    end else begin
      advance(mq, out_ready, m_nq);
      if (in_valid && (m_nq.size() == 0 || m_nq[$].pos > 0)) begin
        m_nq.push_back('{data: in_data, pos: 0});
      end
      mq = m_nq;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic exp_rdy;
      logic exp_ov;
      advance(mq, out_ready, c_nq);
      exp_rdy = !flush && (c_nq.size() == 0 || c_nq[$].pos > 0);
      exp_ov  = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
      check("model_in_ready", in_ready, exp_rdy);
      check("model_out_valid", out_valid, exp_ov);
      check("model_count", count, mq.size());
      if (exp_ov) begin
        check("model_out_data", out_data, mq[0].data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1 rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    #1 flush = 1'b1;
    #1 check("rst_in_ready_flush", in_ready, 0);
    flush = 1'b0;
    tick();

    // Single word through an empty pipe, accepted at the first edge after reset release
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h1111; out_ready = 1'b1;
    @(negedge clk);
    check("lat_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("lat_count", count, 1);
      check("lat_out_valid", out_valid, (k == 4));
      if (k < 4) tick();
    end
    check("lat_out_data", out_data, 16'h1111);
    tick();
    @(negedge clk);
    check("lat_drained_count", count, 0);
    check("lat_drained_valid", out_valid, 0);
    tick();

    // Fill with the consumer stalled, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hA001 + 16'(i);
      @(negedge clk);
      check("fill_in_ready", in_ready, (i < 4));
      if (i == 4) check("fill_count_full", count, 4);
      if (i < 4) tick();
    end
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_out_valid", out_valid, 1);
      check("drain_out_data", out_data, 32'hA001 + i);
      tick();
      if (i == 0) in_valid = 1'b0;
    end

    // Full pipe streaming: one in and one out every cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hB000 + 16'(i);
      tick();
    end
    in_data   = 16'hB004;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      check("stream_out_valid", out_valid, 1);
      check("stream_count", count, 4);
      tick();
      in_data = in_data + 16'd1;
    end
    in_valid = 1'b0;
    repeat (5) tick();

    // Bubble collapse: words at stages 3 and 0 with the consumer stalled
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 16'hC001;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1; in_data = 16'hC002;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bubble_count0", count, 2);
    tick();
    @(negedge clk);
    check("bubble_count1", count, 2);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bubble_count2", count, 2);
    check("bubble_head", out_data, 16'hC001);
    tick();
    @(negedge clk);
    check("bubble_next_valid", out_valid, 1);
    check("bubble_next_data", out_data, 16'hC002);
    check("bubble_next_count", count, 1);
    tick();
    tick();

    // Flush with three words held and both handshakes requested
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hD001 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hD004; out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    check("flush_count_before", count, 3);
    check("flush_out_valid_before", out_valid, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_count_after", count, 0);
    check("flush_out_valid_after", out_valid, 0);
    tick();

    // Asynchronous reset between edges with two words held
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hE001 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("arst_pre_count", count, 2);
    check("arst_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_count", count, 0);
    check("arst_in_ready", in_ready, 1);
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 16'hF001;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_count", count, 1);
    tick();

    // Randomized traffic with a per-block bias on producer and consumer activity
    for (int blk = 0; blk < 20; blk++) begin
      int pv;
      int pr;
      pv = $urandom_range(2, 10);
      pr = $urandom_range(1, 10);
      for (int c = 0; c < 80; c++) begin
        in_valid  = ($urandom_range(1, 10) <= pv);
        in_data   = 16'($urandom);
        out_ready = ($urandom_range(1, 10) <= pr);
        flush     = ($urandom_range(0, 59) == 0);
        tick();
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("final_empty_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: data width in bits, legal range 1 or more.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of register stages, legal range 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all stage contents.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: last stage holds a valid word.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: last-stage word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-012 The block SHALL have port count, output, clog2(DEPTH+1) bits: number of valid stages.

Function
REQ-013 Each stage i (0 = input side, DEPTH-1 = output side) SHALL hold one WIDTH-bit data register and one valid bit.
REQ-014 out_valid SHALL equal valid[DEPTH-1] and out_data SHALL equal data[DEPTH-1], both registered with no combinational path from in_data.
REQ-015 Last-stage advance condition: adv[DEPTH-1] = valid[DEPTH-1] AND out_ready.
REQ-016 Stage i (i < DEPTH-1) SHALL move its word to stage i+1 when valid[i] AND (NOT valid[i+1] OR adv[i+1]); this move is adv[i].
REQ-017 Stages SHALL collapse bubbles: a valid word advances into any empty downstream stage regardless of out_ready.
REQ-018 in_ready SHALL equal (NOT valid[0] OR adv[0]) AND NOT flush; this is a combinational path from out_ready.
REQ-019 Input transfer: occurs when in_valid AND in_ready; stage 0 loads in_data and sets valid[0].
REQ-020 Output transfer: occurs when out_valid AND out_ready; the word is consumed at that edge.
REQ-021 A stage that is emptied and not refilled in the same cycle SHALL clear its valid bit; its data register SHALL hold its old value.
REQ-022 Latency: a word accepted into an empty pipe at edge N SHALL appear on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from acceptance to presentation.
REQ-023 Throughput SHALL be one word per cycle when out_ready is held high; simultaneous input and output transfers are permitted when full.
REQ-024 Full (count = DEPTH) with out_ready = 0: in_ready SHALL be 0 and all stages SHALL hold.
REQ-025 Empty (count = 0): out_valid SHALL be 0; out_ready has no effect.
REQ-026 Word order SHALL be preserved; no word is duplicated or dropped, except on flush.
REQ-027 flush = 1 at an edge SHALL clear all valid bits; that cycle no input is accepted and any output handshake is ignored (the word is discarded, not delivered).
REQ-028 count SHALL equal the population count of the valid bits, updated with them at each edge.
REQ-029 DEPTH = 1 SHALL behave as a single register with handshake, where in_ready = (NOT out_valid OR out_ready) AND NOT flush.

Reset
REQ-030 While rst = 1, all valid bits and all data registers SHALL be 0: out_valid = 0, out_data = 0, count = 0; in_ready = 1 unless flush = 1.
REQ-031 Reset assertion mid-transfer SHALL discard all held words immediately, with no output handshake completing.
REQ-032 The first input transfer SHALL be possible at the first rising edge after rst deasserts.

Verification (WIDTH=16, DEPTH=4)
REQ-033 Bench SHALL cover: after reset, out_ready=1 and 0x1111 presented for one cycle -> out_valid high with out_data=0x1111 exactly 4 cycles after acceptance, count rising 1 then falling 0.
REQ-034 Bench SHALL cover: out_ready=0, push 0xA001..0xA005 -> four accepted, in_ready=0 on the fifth, count=4; then out_ready=1 -> outputs 0xA001..0xA004 in order on consecutive cycles, then 0xA005.
REQ-035 Bench SHALL cover: pipe full, in_valid=1 and out_ready=1 held -> one transfer in and one out every cycle, count stays 4.
REQ-036 Bench SHALL cover: out_ready=0, words at stages 0 and 3 only -> the stage-0 word collapses forward to stage 2 within 2 cycles, and count stays 2.
REQ-037 Bench SHALL cover: count=3, flush pulsed with in_valid=1 and out_ready=1 -> in_ready=0 that cycle, next cycle count=0, out_valid=0, and no word is delivered.
REQ-038 Bench SHALL cover: rst asserted asynchronously between edges with count=2 -> out_valid, out_data and count are 0 immediately, before the next edge.
